// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   state_t        : controller states (IDLE, CALC, FIX)
//   DEFAULT_WIDTH  : default operand/result width
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/div_step.sv
// One unsigned restoring division step (combinational).
//   rem_in  : partial remainder before this step (WIDTH+1 bits)
//   dvd_bit : next dividend bit shifted into the remainder
//   divisor : divisor magnitude (WIDTH+1 bits)
//   rem_out : partial remainder after this step
//   q_bit   : quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           dvd_bit,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    trial   = {rem_in, dvd_bit};
    q_bit   = (trial >= {1'b0, divisor});
    diff    = trial[WIDTH:0] - divisor;
    rem_out = q_bit ? diff : trial[WIDTH:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: truncating quotient, remainder takes the
// dividend's sign. Fixed latency of WIDTH+1 edges from start acceptance.
//   clk, rst     : clock, asynchronous active-high reset
//   start, A, B  : request and signed operands, sampled when busy=0
//   Q, R         : registered signed quotient and remainder
//   busy, done   : operation in flight / one-cycle result-valid pulse
//   div_by_zero  : completed operation had B=0
//   overflow     : completed operation was most-negative / -1
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [WIDTH:0] mag_b;
  logic [WIDTH:0] dvd_q;   // dividend bits shift out the top, quotient bits fill the bottom
  logic [WIDTH:0] rem_q;
  logic           q_neg, r_neg, zero_q, ovf_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_nx;
  logic             q_bit;

  // Unsigned W-bit magnitude is lossless even for the most negative value.
  always_comb begin
    abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH]),
    .divisor (mag_b),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mag_b       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_b  <= {1'b0, abs_b};
            dvd_q  <= {abs_a, 1'b0};
            rem_q  <= '0;
            cnt_q  <= '0;
            q_neg  <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg  <= A[WIDTH-1];
            zero_q <= (B == '0);
            ovf_q  <= (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
            busy   <= 1'b1;
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          dvd_q <= {dvd_q[WIDTH-1:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          // With B=0 the steps leave |A| in the remainder, so only Q needs forcing;
          // the overflow case wraps naturally to the most negative value.
          if (zero_q)
            Q <= '1;
          else
            Q <= q_neg ? -dvd_q[WIDTH-1:0] : dvd_q[WIDTH-1:0];
          R           <= r_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          div_by_zero <= zero_q;
          overflow    <= ovf_q;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B, Q, R;
  logic         busy, done, div_by_zero, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] prev_q, prev_r;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz, ov;
    string        name;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge while idle or while done is high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eov,
                        input bit keep, input string name);
    int cnt;
    bit seen;
    A = a; B = b; start = 1'b1;
    cnt = 0; seen = 0;
    while (cnt < 12 && !seen) begin
      @(negedge clk);
      cnt++;
      if (!keep) start = 1'b0;
      if (cnt == 3) check({name, " hold"}, {busy, Q, R}, {1'b1, prev_q, prev_r});
      if (done) seen = 1;
    end
    check({name, " latency"}, cnt, 6);
    check({name, " result"}, {Q, R, div_by_zero, overflow}, {eq, er, edz, eov});
    prev_q = eq; prev_r = er;
  endtask

  function automatic void model(input int a, input int b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    dz = 1'b0; ov = 1'b0;
    if (b == 0) begin
      q = '1; r = 4'(a); dz = 1'b1;
    end else if (a == -8 && b == -1) begin
      q = 4'h8; r = '0; ov = 1'b1;
    end else begin
      q = 4'(a / b); r = 4'(a % b);
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, pulses;
    bit seen;
    logic [W-1:0] eq, er;
    logic edz, eov;

    vt[0]  = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, "7/2"};
    vt[1]  = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, "-7/2"};
    vt[2]  = '{4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0, "7/-2"};
    vt[3]  = '{4'h9, 4'hE, 4'h3, 4'hF, 1'b0, 1'b0, "-7/-2"};
    vt[4]  = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, "-8/-1"};
    vt[5]  = '{4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, "5/0"};
    vt[6]  = '{4'h8, 4'h0, 4'hF, 4'h8, 1'b1, 1'b0, "-8/0"};
    vt[7]  = '{4'h0, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, "0/3"};
    vt[8]  = '{4'h8, 4'h3, 4'hE, 4'hE, 1'b0, 1'b0, "-8/3"};
    vt[9]  = '{4'h3, 4'h7, 4'h0, 4'h3, 1'b0, 1'b0, "3/7"};
    vt[10] = '{4'hF, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0, "-1/1"};
    vt[11] = '{4'h7, 4'h7, 4'h1, 4'h0, 1'b0, 1'b0, "7/7"};
    vt[12] = '{4'h7, 4'h9, 4'hF, 4'h0, 1'b0, 1'b0, "7/-7"};
    vt[13] = '{4'h8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0, "-8/1"};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset state", {Q, R, busy, done, div_by_zero, overflow}, '0);
    rst = 1'b0;
    @(negedge clk);
    prev_q = '0; prev_r = '0;

    for (int i = 0; i < 14; i++)
      run_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].ov, 1'b0, vt[i].name);

    // Second start at edge 2 must be ignored.
    @(negedge clk);
    A = 4'h7; B = 4'h2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); A = 4'h9; B = 4'hE; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 3; seen = done;
    while (cnt < 12 && !seen) begin
      @(negedge clk);
      cnt++;
      if (done) seen = 1;
    end
    check("ignored start latency", cnt, 6);
    check("ignored start result", {Q, R, div_by_zero, overflow}, {4'h3, 4'h1, 1'b0, 1'b0});
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ignored start not queued", {pulses, 1'b0 ^ busy}, {32'd0, 1'b0});
    prev_q = 4'h3; prev_r = 4'h1;

    // Reset asserted mid-calculation, held across edge 3.
    A = 4'h5; B = 4'h2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset clears", {Q, R, busy, done, div_by_zero, overflow}, '0);
    @(negedge clk);
    check("reset no done", {Q, R, busy, done, div_by_zero, overflow}, '0);
    rst = 1'b0;
    prev_q = '0; prev_r = '0;
    run_op(4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 1'b0, "after reset");

    // Exhaustive back-to-back sweep, start held high throughout.
    for (int ai = -8; ai < 8; ai++) begin
      for (int bi = -8; bi < 8; bi++) begin
        model(ai, bi, eq, er, edz, eov);
        run_op(4'(ai), 4'(bi), eq, er, edz, eov, 1'b1, $sformatf("sweep %0d/%0d", ai, bi));
      end
    end
    start = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
